// File: rtl/alu_reservation_station_if.sv
// rtl/alu_reservation_station_if.sv - dispatch, CDB, issue and status bundle of the ALU reservation station
interface alu_reservation_station_if #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 64
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [4:0]        disp_alu_op;
  logic [TAG_W-1:0]  disp_dst_tag;
  logic              disp_a_rdy;
  logic [TAG_W-1:0]  disp_a_tag;
  logic [DATA_W-1:0] disp_a_val;
  logic              disp_b_rdy;
  logic [TAG_W-1:0]  disp_b_tag;
  logic [DATA_W-1:0] disp_b_val;
  logic [5:0]        disp_valhw;
  logic              disp_set_cc;
  logic [4:0]        disp_cond;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_val;
  logic              iss_valid;
  logic              iss_ready;
  logic [4:0]        iss_alu_op;
  logic [DATA_W-1:0] iss_vala;
  logic [DATA_W-1:0] iss_valb;
  logic [5:0]        iss_valhw;
  logic              iss_set_cc;
  logic [4:0]        iss_cond;
  logic [TAG_W-1:0]  iss_dst_tag;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output flush, disp_valid, disp_alu_op, disp_dst_tag,
           disp_a_rdy, disp_a_tag, disp_a_val,
           disp_b_rdy, disp_b_tag, disp_b_val,
           disp_valhw, disp_set_cc, disp_cond,
           cdb_valid, cdb_tag, cdb_val, iss_ready,
    input  disp_ready, iss_valid, iss_alu_op, iss_vala, iss_valb,
           iss_valhw, iss_set_cc, iss_cond, iss_dst_tag, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_alu_op, disp_dst_tag,
           disp_a_rdy, disp_a_tag, disp_a_val,
           disp_b_rdy, disp_b_tag, disp_b_val,
           disp_valhw, disp_set_cc, disp_cond,
           cdb_valid, cdb_tag, cdb_val, iss_ready,
    output disp_ready, iss_valid, iss_alu_op, iss_vala, iss_valb,
           iss_valhw, iss_set_cc, iss_cond, iss_dst_tag, occupancy
  );
endinterface

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - collapsing-queue Tomasulo station feeding the ALU
// Slot 0 is the oldest entry; slots at or above occ_q hold stale data and are never issued.
module alu_reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  alu_reservation_station_if.slave rs_if
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]        alu_op;
    logic [TAG_W-1:0]  dst_tag;
    logic              a_rdy;
    logic [TAG_W-1:0]  a_tag;
    logic [DATA_W-1:0] a_val;
    logic              b_rdy;
    logic [TAG_W-1:0]  b_tag;
    logic [DATA_W-1:0] b_val;
    logic [5:0]        valhw;
    logic              set_cc;
    logic [4:0]        cond;
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  entry_t           cap     [DEPTH];
  entry_t           new_e;
  entry_t           sel_e;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] wr_idx;
  logic [DEPTH-1:0] elig;
  logic [IDX_W-1:0] sel;
  logic             any_elig;
  logic             iss_fire;
  logic             disp_fire;
  logic             disp_ready;

  function automatic entry_t capture(entry_t e, logic v, logic [TAG_W-1:0] t,
                                     logic [DATA_W-1:0] d);
    entry_t r;
    r = e;
    if (v && !e.a_rdy && (e.a_tag == t)) begin
      r.a_rdy = 1'b1;
      r.a_val = d;
    end
    if (v && !e.b_rdy && (e.b_tag == t)) begin
      r.b_rdy = 1'b1;
      r.b_val = d;
    end
    return r;
  endfunction

  // Eligibility uses registered rdy bits only, so a capture never issues in its own cycle.
  always_comb begin
    elig     = '0;
    sel      = '0;
    any_elig = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = (i < int'(occ_q)) && entry_q[i].a_rdy && entry_q[i].b_rdy;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel      = IDX_W'(i);
        any_elig = 1'b1;
      end
    end
  end

  assign sel_e      = entry_q[sel];
  assign disp_ready = occ_q < OCC_W'(DEPTH);
  assign iss_fire   = any_elig && rs_if.iss_ready;
  // A full station still accepts a dispatch when the same edge issues an entry.
  assign disp_fire  = rs_if.disp_valid && (disp_ready || iss_fire);
  assign wr_idx     = occ_q - OCC_W'(iss_fire);

  assign rs_if.disp_ready  = disp_ready;
  assign rs_if.occupancy   = occ_q;
  assign rs_if.iss_valid   = any_elig;
  assign rs_if.iss_alu_op  = any_elig ? sel_e.alu_op  : '0;
  assign rs_if.iss_vala    = any_elig ? sel_e.a_val   : '0;
  assign rs_if.iss_valb    = any_elig ? sel_e.b_val   : '0;
  assign rs_if.iss_valhw   = any_elig ? sel_e.valhw   : '0;
  assign rs_if.iss_set_cc  = any_elig ? sel_e.set_cc  : 1'b0;
  assign rs_if.iss_cond    = any_elig ? sel_e.cond    : '0;
  assign rs_if.iss_dst_tag = any_elig ? sel_e.dst_tag : '0;

  always_comb begin
    new_e.alu_op  = rs_if.disp_alu_op;
    new_e.dst_tag = rs_if.disp_dst_tag;
    new_e.a_rdy   = rs_if.disp_a_rdy;
    new_e.a_tag   = rs_if.disp_a_tag;
    new_e.a_val   = rs_if.disp_a_val;
    new_e.b_rdy   = rs_if.disp_b_rdy;
    new_e.b_tag   = rs_if.disp_b_tag;
    new_e.b_val   = rs_if.disp_b_val;
    new_e.valhw   = rs_if.disp_valhw;
    new_e.set_cc  = rs_if.disp_set_cc;
    new_e.cond    = rs_if.disp_cond;
  end

  // Capture first, then collapse, so captured bits travel with their entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cap[i]     = capture(entry_q[i], rs_if.cdb_valid, rs_if.cdb_tag, rs_if.cdb_val);
      entry_d[i] = cap[i];
    end
    if (iss_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel)) entry_d[i] = cap[i+1];
      end
    end
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(wr_idx)) begin
          entry_d[i] = capture(new_e, rs_if.cdb_valid, rs_if.cdb_tag, rs_if.cdb_val);
        end
      end
    end
    occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(iss_fire);
    if (rs_if.flush) occ_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end
endmodule
